// File: rtl/pe_multimode_if.sv
// pe_multimode_if: neighbour-facing bus of one multimode systolic PE.
//   Inputs to the PE : op_in[2:0] (mode/os_drain/wgt_load), acc_clr, valid_in,
//                      act_in (west), wgt_in (north), psum_in (north).
//   Outputs of the PE: act_out/op_out/valid_out (east), wgt_out (south),
//                      psum_out (south), ovf_flag (sticky overflow).
//   modport master: the side that drives the PE (array edge logic or bench).
//   modport slave : the PE itself.
interface pe_multimode_if #(
    parameter int ACT_WIDTH    = 8,
    parameter int WGT_WIDTH    = 8,
    parameter int PE_OUT_WIDTH = 32
);
    logic        [2:0]              op_in;
    logic                           acc_clr;
    logic                           valid_in;
    logic        [ACT_WIDTH-1:0]    act_in;
    logic signed [WGT_WIDTH-1:0]    wgt_in;
    logic signed [PE_OUT_WIDTH-1:0] psum_in;

    logic        [ACT_WIDTH-1:0]    act_out;
    logic signed [WGT_WIDTH-1:0]    wgt_out;
    logic        [2:0]              op_out;
    logic                           valid_out;
    logic signed [PE_OUT_WIDTH-1:0] psum_out;
    logic                           ovf_flag;

    modport master (
        output op_in, acc_clr, valid_in, act_in, wgt_in, psum_in,
        input  act_out, wgt_out, op_out, valid_out, psum_out, ovf_flag
    );

    modport slave (
        input  op_in, acc_clr, valid_in, act_in, wgt_in, psum_in,
        output act_out, wgt_out, op_out, valid_out, psum_out, ovf_flag
    );
endinterface

// File: rtl/pe_multimode.sv
// pe_multimode: systolic-array processing element with two runtime dataflows.
//   Output-stationary (op_in[2]=1): accumulates act*wgt in place, drains the
//   result down the column through psum_in -> psum_out when os_drain is set.
//   Weight-stationary (op_in[2]=0): holds a preloaded weight; each valid cycle
//   adds act*weight to the partial sum passing from north to south.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; clears every register
//   bus   - pe_multimode_if.slave carrying operands, control, forwarded
//           neighbour signals, psum_out and the sticky ovf_flag
module pe_multimode #(
    parameter int ACT_WIDTH    = 8,
    parameter int WGT_WIDTH    = 8,
    parameter int PE_OUT_WIDTH = 32,
    parameter int ACT_SIGNED   = 0,
    parameter int SATURATE     = 1
) (
    input  logic           clk,
    input  logic           reset,
    pe_multimode_if.slave  bus
);
    // Product width holds ext(act) * wgt exactly; sum width adds one guard bit.
    localparam int PW = ACT_WIDTH + WGT_WIDTH + 1;
    localparam int SW = PE_OUT_WIDTH + 1;

    localparam logic signed [PE_OUT_WIDTH-1:0] MAX_C = {1'b0, {(PE_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PE_OUT_WIDTH-1:0] MIN_C = {1'b1, {(PE_OUT_WIDTH-1){1'b0}}};
    localparam logic                           SAT_C = (SATURATE != 0);
    localparam logic                           SGN_C = (ACT_SIGNED != 0);

    // Overflow of the guarded sum: the two top bits disagree.
    function automatic logic ovf_fn(input logic [SW-1:0] sum);
        ovf_fn = sum[SW-1] ^ sum[SW-2];
    endfunction

    // Reduce the guarded sum to W bits, clamping or wrapping on overflow.
    function automatic logic [PE_OUT_WIDTH-1:0] clamp_fn(input logic [SW-1:0] sum,
                                                         input logic sat_en);
        if (ovf_fn(sum) && sat_en) begin
            clamp_fn = sum[SW-1] ? MIN_C : MAX_C;
        end else begin
            clamp_fn = sum[SW-2:0];
        end
    endfunction

    logic        [ACT_WIDTH-1:0]    act_q,   act_d;
    logic        [WGT_WIDTH-1:0]    wgt_q,   wgt_d;
    logic        [2:0]              op_q,    op_d;
    logic                           valid_q, valid_d;
    logic        [PE_OUT_WIDTH-1:0] acc_q,   acc_d;
    logic        [WGT_WIDTH-1:0]    wreg_q,  wreg_d;
    logic                           ovf_q,   ovf_d;

    logic                           mode_os_s;
    logic                           drain_s;
    logic                           load_s;
    logic        [ACT_WIDTH:0]      act_ext_s;
    logic        [WGT_WIDTH-1:0]    wgt_sel_s;
    logic        [PW-1:0]           act_wide_s;
    logic        [PW-1:0]           wgt_wide_s;
    logic        [PW-1:0]           prod_s;
    logic        [SW-1:0]           prod_ext_s;
    logic        [PE_OUT_WIDTH-1:0] addend_s;
    logic        [SW-1:0]           sum_s;
    logic        [PE_OUT_WIDTH-1:0] mac_res_s;
    logic                           mac_ovf_s;

    // Datapath: operand extension, multiply, guarded add and clamp.
    always_comb begin
        mode_os_s  = bus.op_in[2];
        drain_s    = bus.op_in[1];
        load_s     = bus.op_in[0];
        act_ext_s  = SGN_C ? {bus.act_in[ACT_WIDTH-1], bus.act_in}
                           : {1'b0, bus.act_in};
        // OS multiplies by the streaming weight, WS by the stationary one.
        wgt_sel_s  = mode_os_s ? bus.wgt_in : wreg_q;
        act_wide_s = {{(PW-ACT_WIDTH-1){act_ext_s[ACT_WIDTH]}}, act_ext_s};
        wgt_wide_s = {{(PW-WGT_WIDTH){wgt_sel_s[WGT_WIDTH-1]}}, wgt_sel_s};
        prod_s     = $signed(act_wide_s) * $signed(wgt_wide_s);
        prod_ext_s = {{(SW-PW){prod_s[PW-1]}}, prod_s};
        addend_s   = mode_os_s ? acc_q : bus.psum_in;
        sum_s      = {addend_s[PE_OUT_WIDTH-1], addend_s} + prod_ext_s;
        mac_res_s  = clamp_fn(sum_s, SAT_C);
        mac_ovf_s  = ovf_fn(sum_s);
    end

    // Next-state selection for forwarding, accumulator, weight and flag.
    always_comb begin
        act_d   = bus.act_in;
        wgt_d   = bus.wgt_in;
        op_d    = bus.op_in;
        valid_d = bus.valid_in;
        acc_d   = acc_q;
        wreg_d  = wreg_q;
        ovf_d   = ovf_q;
        if (mode_os_s) begin
            if (drain_s) begin
                // Drain shifts the column; a concurrent MAC is dropped.
                acc_d = bus.psum_in;
            end else if (bus.acc_clr) begin
                ovf_d = 1'b0;
                // Clear-and-start: a lone product always fits in W bits.
                acc_d = bus.valid_in ? prod_ext_s[PE_OUT_WIDTH-1:0]
                                     : {PE_OUT_WIDTH{1'b0}};
            end else if (bus.valid_in) begin
                acc_d = mac_res_s;
                ovf_d = ovf_q | mac_ovf_s;
            end else begin
                acc_d = acc_q;
            end
        end else begin
            // The MAC above already used the old weight; a load lands after it.
            if (load_s) begin
                wreg_d = bus.wgt_in;
            end else begin
                wreg_d = wreg_q;
            end
            if (bus.valid_in) begin
                acc_d = mac_res_s;
            end else begin
                acc_d = bus.psum_in;
            end
            // acc_clr clears history; an overflow in this same cycle still shows.
            ovf_d = (ovf_q & ~bus.acc_clr) | (bus.valid_in & mac_ovf_s);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q   <= {ACT_WIDTH{1'b0}};
            wgt_q   <= {WGT_WIDTH{1'b0}};
            op_q    <= 3'b000;
            valid_q <= 1'b0;
            acc_q   <= {PE_OUT_WIDTH{1'b0}};
            wreg_q  <= {WGT_WIDTH{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            act_q   <= act_d;
            wgt_q   <= wgt_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            wreg_q  <= wreg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.act_out   = act_q;
    assign bus.wgt_out   = wgt_q;
    assign bus.op_out    = op_q;
    assign bus.valid_out = valid_q;
    assign bus.psum_out  = acc_q;
    assign bus.ovf_flag  = ovf_q;
endmodule

// File: tb/tb_pe_multimode.sv
module tb_pe_multimode;
    logic        clk = 1'b0;
    logic        t_rst;
    logic [2:0]  t_op;
    logic        t_clr, t_vld;
    logic [7:0]  t_act, t_wgt;
    logic [31:0] t_psum;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Four configurations: 0 = W32 unsigned sat, 1 = W16 sat, 2 = W16 wrap,
    // 3 = W32 signed-activation sat.
    int W_C   [4] = '{32, 16, 16, 32};
    bit SAT_C [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit SGN_C [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    pe_multimode_if #(.ACT_WIDTH(8), .WGT_WIDTH(8), .PE_OUT_WIDTH(32)) if0 ();
    pe_multimode_if #(.ACT_WIDTH(8), .WGT_WIDTH(8), .PE_OUT_WIDTH(16)) if1 ();
    pe_multimode_if #(.ACT_WIDTH(8), .WGT_WIDTH(8), .PE_OUT_WIDTH(16)) if2 ();
    pe_multimode_if #(.ACT_WIDTH(8), .WGT_WIDTH(8), .PE_OUT_WIDTH(32)) if3 ();

    pe_multimode #(.PE_OUT_WIDTH(32), .ACT_SIGNED(0), .SATURATE(1)) dut0 (.clk(clk), .reset(t_rst), .bus(if0));
    pe_multimode #(.PE_OUT_WIDTH(16), .ACT_SIGNED(0), .SATURATE(1)) dut1 (.clk(clk), .reset(t_rst), .bus(if1));
    pe_multimode #(.PE_OUT_WIDTH(16), .ACT_SIGNED(0), .SATURATE(0)) dut2 (.clk(clk), .reset(t_rst), .bus(if2));
    pe_multimode #(.PE_OUT_WIDTH(32), .ACT_SIGNED(1), .SATURATE(1)) dut3 (.clk(clk), .reset(t_rst), .bus(if3));

    assign if0.op_in = t_op;  assign if0.acc_clr = t_clr; assign if0.valid_in = t_vld;
    assign if0.act_in = t_act; assign if0.wgt_in = t_wgt; assign if0.psum_in = t_psum;
    assign if1.op_in = t_op;  assign if1.acc_clr = t_clr; assign if1.valid_in = t_vld;
    assign if1.act_in = t_act; assign if1.wgt_in = t_wgt; assign if1.psum_in = t_psum[15:0];
    assign if2.op_in = t_op;  assign if2.acc_clr = t_clr; assign if2.valid_in = t_vld;
    assign if2.act_in = t_act; assign if2.wgt_in = t_wgt; assign if2.psum_in = t_psum[15:0];
    assign if3.op_in = t_op;  assign if3.acc_clr = t_clr; assign if3.valid_in = t_vld;
    assign if3.act_in = t_act; assign if3.wgt_in = t_wgt; assign if3.psum_in = t_psum;

    longint     d_psum [4];
    logic       d_ovf  [4];
    logic [7:0] d_act  [4];
    logic [7:0] d_wgt  [4];
    logic [2:0] d_op   [4];
    logic       d_vld  [4];

    assign d_psum[0] = longint'(if0.psum_out); assign d_psum[1] = longint'(if1.psum_out);
    assign d_psum[2] = longint'(if2.psum_out); assign d_psum[3] = longint'(if3.psum_out);
    assign d_ovf[0] = if0.ovf_flag; assign d_ovf[1] = if1.ovf_flag;
    assign d_ovf[2] = if2.ovf_flag; assign d_ovf[3] = if3.ovf_flag;
    assign d_act[0] = if0.act_out;  assign d_act[1] = if1.act_out;
    assign d_act[2] = if2.act_out;  assign d_act[3] = if3.act_out;
    assign d_wgt[0] = if0.wgt_out;  assign d_wgt[1] = if1.wgt_out;
    assign d_wgt[2] = if2.wgt_out;  assign d_wgt[3] = if3.wgt_out;
    assign d_op[0]  = if0.op_out;   assign d_op[1]  = if1.op_out;
    assign d_op[2]  = if2.op_out;   assign d_op[3]  = if3.op_out;
    assign d_vld[0] = if0.valid_out; assign d_vld[1] = if1.valid_out;
    assign d_vld[2] = if2.valid_out; assign d_vld[3] = if3.valid_out;

    // Reference model: integer arithmetic on mathematical values.
    longint     m_acc  [4];
    longint     m_wreg [4];
    bit         m_ovf  [4];
    logic [7:0] m_act, m_wgt;
    logic [2:0] m_op;
    logic       m_vld;

    function automatic longint sext(input longint v, input int w);
        longint one = 1;
        longint r = v & ((one << w) - 1);
        if (r >= (one << (w - 1))) r = r - (one << w);
        return r;
    endfunction

    function automatic longint fit(input longint s, input int w, input bit sat, output bit o);
        longint one = 1;
        longint mx = (one << (w - 1)) - 1;
        longint mn = -mx - 1;
        o = (s > mx) || (s < mn);
        if (!o) return s;
        if (sat) return (s > mx) ? mx : mn;
        return sext(s, w);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            longint a   = SGN_C[k] ? longint'($signed(t_act)) : longint'(t_act);
            longint wg  = longint'($signed(t_wgt));
            longint pin = sext(longint'(t_psum), W_C[k]);
            bit o = 1'b0;
            if (t_rst) begin
                m_acc[k] = 0; m_wreg[k] = 0; m_ovf[k] = 1'b0;
            end else if (t_op[2]) begin
                if (t_op[1]) m_acc[k] = pin;
                else if (t_clr) begin
                    m_ovf[k] = 1'b0;
                    m_acc[k] = t_vld ? a * wg : 0;
                end else if (t_vld) begin
                    m_acc[k] = fit(m_acc[k] + a * wg, W_C[k], SAT_C[k], o);
                    m_ovf[k] = m_ovf[k] | o;
                end
            end else begin
                if (t_vld) m_acc[k] = fit(pin + a * m_wreg[k], W_C[k], SAT_C[k], o);
                else       m_acc[k] = pin;
                m_ovf[k] = (m_ovf[k] & !t_clr) | o;
                if (t_op[0]) m_wreg[k] = wg;
            end
        end
        m_act = t_rst ? 8'h00 : t_act;
        m_wgt = t_rst ? 8'h00 : t_wgt;
        m_op  = t_rst ? 3'b000 : t_op;
        m_vld = t_rst ? 1'b0 : t_vld;
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("psum_out[%0d]", k), d_psum[k], m_acc[k]);
            chk($sformatf("ovf_flag[%0d]", k), longint'(d_ovf[k]), longint'(m_ovf[k]));
            chk($sformatf("act_out[%0d]", k), longint'(d_act[k]), longint'(m_act));
            chk($sformatf("wgt_out[%0d]", k), longint'(d_wgt[k]), longint'(m_wgt));
            chk($sformatf("op_out[%0d]", k), longint'(d_op[k]), longint'(m_op));
            chk($sformatf("valid_out[%0d]", k), longint'(d_vld[k]), longint'(m_vld));
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic r, input logic [2:0] op, input logic c, input logic v,
                         input logic [7:0] a, input logic [7:0] w, input logic [31:0] p);
        t_rst = r; t_op = op; t_clr = c; t_vld = v; t_act = a; t_wgt = w; t_psum = p;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        clr, vld;
        logic [7:0]  act, wgt;
        logic [31:0] psum;
        bit          adv;   // 0: check another DUT in the same cycle
        int          dut;
        longint      ep;
        bit          eo;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(input logic [2:0] op, input logic c, input logic v,
                                 input logic [7:0] a, input logic [7:0] w, input logic [31:0] p,
                                 input bit adv, input int dut, input longint ep, input bit eo);
        vec_t e;
        e.op = op; e.clr = c; e.vld = v; e.act = a; e.wgt = w; e.psum = p;
        e.adv = adv; e.dut = dut; e.ep = ep; e.eo = eo;
        tbl.push_back(e);
    endfunction

    initial begin
        // OS accumulate, unsigned activations
        addv(3'b100, 1'b1, 1'b0, 8'd0,   8'd0,   32'd0,    1'b1, 0, 0,      1'b0);
        addv(3'b100, 1'b0, 1'b1, 8'd200, 8'hFD,  32'd0,    1'b1, 0, -600,   1'b0);
        addv(3'b100, 1'b0, 1'b1, 8'd10,  8'd5,   32'd0,    1'b1, 0, -550,   1'b0);
        addv(3'b100, 1'b0, 1'b1, 8'd255, 8'd127, 32'd0,    1'b1, 0, 31835,  1'b0);
        addv(3'b100, 1'b0, 1'b1, 8'd1,   8'hFF,  32'd0,    1'b1, 0, 31834,  1'b0);
        // drain beats MAC, then clear-and-start
        addv(3'b110, 1'b0, 1'b1, 8'd9,   8'd9,   32'd7,    1'b1, 0, 7,      1'b0);
        addv(3'b100, 1'b1, 1'b1, 8'd2,   8'd3,   32'd0,    1'b1, 0, 6,      1'b0);
        // WS load/MAC collision, new weight, bubble
        addv(3'b001, 1'b0, 1'b1, 8'd5,   8'd4,   32'd10,   1'b1, 0, 10,     1'b0);
        addv(3'b000, 1'b0, 1'b1, 8'd5,   8'd0,   32'd10,   1'b1, 0, 30,     1'b0);
        addv(3'b000, 1'b0, 1'b0, 8'd5,   8'd0,   32'd99,   1'b1, 0, 99,     1'b0);
        // 16-bit saturate vs wrap
        addv(3'b110, 1'b0, 1'b0, 8'd0,   8'd0,   32'd32700, 1'b1, 1, 32700, 1'b0);
        addv(3'b100, 1'b0, 1'b1, 8'd255, 8'd127, 32'd0,    1'b1, 1, 32767,  1'b1);
        addv(3'b100, 1'b0, 1'b1, 8'd255, 8'd127, 32'd0,    1'b0, 2, -451,   1'b1);
        addv(3'b100, 1'b0, 1'b1, 8'd255, 8'd127, 32'd0,    1'b0, 0, 65085,  1'b0);
        addv(3'b100, 1'b1, 1'b0, 8'd0,   8'd0,   32'd0,    1'b1, 1, 0,      1'b0);
        addv(3'b100, 1'b1, 1'b0, 8'd0,   8'd0,   32'd0,    1'b0, 2, 0,      1'b0);
        // signed vs unsigned activations
        addv(3'b100, 1'b1, 1'b1, 8'h80,  8'h80,  32'd0,    1'b1, 3, 16384,  1'b0);
        addv(3'b100, 1'b1, 1'b1, 8'h80,  8'h80,  32'd0,    1'b0, 0, -16384, 1'b0);
        addv(3'b100, 1'b0, 1'b1, 8'hFF,  8'h01,  32'd0,    1'b1, 3, 16383,  1'b0);
        addv(3'b100, 1'b0, 1'b1, 8'hFF,  8'h01,  32'd0,    1'b0, 0, -16129, 1'b0);
        // WS saturation on the through-flowing sum (weight 4 held from above)
        addv(3'b000, 1'b0, 1'b1, 8'hFF,  8'h00,  32'h7FFF, 1'b1, 1, 32767,  1'b1);
        addv(3'b000, 1'b0, 1'b1, 8'hFF,  8'h00,  32'h7FFF, 1'b0, 2, -31749, 1'b1);
        addv(3'b000, 1'b0, 1'b1, 8'hFF,  8'h00,  32'h7FFF, 1'b0, 0, 33787,  1'b0);
        addv(3'b000, 1'b0, 1'b1, 8'hFF,  8'h00,  32'h7FFF, 1'b0, 3, 32763,  1'b0);
        // WS acc_clr clears only the flag
        addv(3'b000, 1'b1, 1'b0, 8'd0,   8'd0,   32'd5,    1'b1, 1, 5,      1'b0);

        drive(1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0; m_wreg[k] = 0; m_ovf[k] = 1'b0;
        end
        @(negedge clk);
        cycle();
        cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].adv) begin
                drive(1'b0, tbl[i].op, tbl[i].clr, tbl[i].vld, tbl[i].act, tbl[i].wgt, tbl[i].psum);
                cycle();
            end
            chk($sformatf("vec%0d psum[%0d]", i, tbl[i].dut), d_psum[tbl[i].dut], tbl[i].ep);
            chk($sformatf("vec%0d ovf[%0d]", i, tbl[i].dut),
                longint'(d_ovf[tbl[i].dut]), longint'(tbl[i].eo));
        end

        // Reset in the middle of an OS drain
        drive(1'b0, 3'b110, 1'b0, 1'b1, 8'h11, 8'h22, 32'd55);
        cycle();
        drive(1'b1, 3'b110, 1'b0, 1'b1, 8'h11, 8'h22, 32'd56);
        cycle();
        chk("rst_drain psum", d_psum[0], 0);
        chk("rst_drain act_out", longint'(d_act[0]), 0);
        chk("rst_drain op_out", longint'(d_op[0]), 0);
        // Reset during a WS weight load
        drive(1'b1, 3'b001, 1'b0, 1'b1, 8'h44, 8'h07, 32'd9);
        cycle();
        chk("rst_load wgt_out", longint'(d_wgt[0]), 0);
        chk("rst_load valid_out", longint'(d_vld[0]), 0);
        drive(1'b0, 3'b001, 1'b0, 1'b1, 8'h3C, 8'h03, 32'd0);
        cycle();
        chk("post_rst act_out", longint'(d_act[0]), 60);
        chk("post_rst wgt_out", longint'(d_wgt[0]), 3);
        chk("post_rst op_out", longint'(d_op[0]), 1);
        chk("post_rst psum", d_psum[0], 0);
        drive(1'b0, 3'b000, 1'b0, 1'b1, 8'h02, 8'h00, 32'd1);
        cycle();
        chk("post_rst ws mac", d_psum[0], 7);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] p;
            case ($urandom_range(3, 0))
                0: p = $urandom;
                1: p = $urandom_range(200, 0);
                2: p = 32'h7F00 + $urandom_range(255, 0);
                default: p = 32'h7FFF_0000 + $urandom_range(65535, 0);
            endcase
            drive(($urandom_range(99, 0) == 0), 3'($urandom_range(7, 0)),
                  ($urandom_range(7, 0) == 0), ($urandom_range(3, 0) != 0),
                  8'($urandom), 8'($urandom), p);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
